// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter controller for the fetch stage.
//
// Holds the current fetch address and selects the next one. The choices,
// highest priority first, are: trap vector, stall (hold), return (pop from
// the internal return-address stack), call (push PC+STEP, go to target),
// absolute jump, PC-relative branch, and sequential PC+STEP.
//
// Ports:
//   CLOCK          rising-edge clock
//   RESET          asynchronous active-high reset
//   STALL          hold PC, RAS and flags (TRAP overrides it)
//   TRAP/TRAP_VEC  redirect to the trap vector; the RAS is not touched
//   BR_TAKEN       take the PC-relative branch PC+BR_OFFSET
//   BR_OFFSET      two's-complement byte offset
//   JUMP           absolute jump to JUMP_TARGET
//   CALL           push PC+STEP and go to JUMP_TARGET
//   RET            pop the RAS and go to the popped address
//   JUMP_TARGET    target for JUMP and CALL
//   PC             registered current fetch address
//   NPC            value PC takes at the next edge (combinational)
//   RAS_COUNT      number of valid RAS entries
//   MISALIGN       one-cycle pulse: last accepted redirect target was misaligned
//   RAS_UNDERFLOW  sticky: a RET was issued while the RAS was empty
module pc_ctrl #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0,
  parameter int               STEP       = 4,
  parameter int               ALIGN_BITS = 2,
  parameter int               RAS_DEPTH  = 4
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       STALL,
  input  logic                       TRAP,
  input  logic [WIDTH-1:0]           TRAP_VEC,
  input  logic                       BR_TAKEN,
  input  logic [WIDTH-1:0]           BR_OFFSET,
  input  logic                       JUMP,
  input  logic                       CALL,
  input  logic                       RET,
  input  logic [WIDTH-1:0]           JUMP_TARGET,
  output logic [WIDTH-1:0]           PC,
  output logic [WIDTH-1:0]           NPC,
  output logic [$clog2(RAS_DEPTH):0] RAS_COUNT,
  output logic                       MISALIGN,
  output logic                       RAS_UNDERFLOW
);

  localparam int               PTR_W      = $clog2(RAS_DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [WIDTH-1:0] STEP_V     = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] DEPTH_V    = CNT_W'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  // Clear the low ALIGN_BITS of a redirect target.
  function automatic logic [WIDTH-1:0] align_target(input logic [WIDTH-1:0] t);
    return t & ~ALIGN_MASK;
  endfunction

  // Any of the low ALIGN_BITS set.
  function automatic logic is_misaligned(input logic [WIDTH-1:0] t);
    return |(t & ALIGN_MASK);
  endfunction

  logic [WIDTH-1:0] cur_pc;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  // wr_ptr is the slot the next push writes; the top entry sits one below.
  // When the stack is full that slot holds the oldest entry, so a push
  // naturally overwrites it.
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             misalign;
  logic             underflow;

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] br_sum;
  logic [PTR_W-1:0] top_idx;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;

  logic [WIDTH-1:0] raw_target;
  logic             redirect;
  logic             hold;
  logic             do_push;
  logic             do_pop;
  logic             do_replace;
  logic             uf_set;
  logic [WIDTH-1:0] next_pc;
  logic             next_misalign;

  // Both sums wrap modulo 2^WIDTH; the carry is simply dropped.
  assign seq_pc    = cur_pc + STEP_V;
  assign br_sum    = cur_pc + BR_OFFSET;
  assign top_idx   = wr_ptr - PTR_W'(1);
  assign ras_top   = ras[top_idx];
  assign ras_empty = (count == '0);

  always_comb begin
    raw_target = seq_pc;
    redirect   = 1'b0;
    hold       = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_replace = 1'b0;
    uf_set     = 1'b0;
    if (TRAP) begin
      raw_target = TRAP_VEC;
      redirect   = 1'b1;
    end else if (STALL) begin
      hold = 1'b1;
    end else if (RET) begin
      if (!ras_empty) begin
        raw_target = ras_top;
        redirect   = 1'b1;
        // RET+CALL swaps the top entry in place instead of pop-then-push.
        if (CALL) do_replace = 1'b1;
        else      do_pop     = 1'b1;
      end else begin
        uf_set = 1'b1;
        // Empty-stack RET+CALL degrades to a plain CALL; lone RET falls through.
        if (CALL) begin
          raw_target = JUMP_TARGET;
          redirect   = 1'b1;
          do_push    = 1'b1;
        end
      end
    end else if (CALL) begin
      raw_target = JUMP_TARGET;
      redirect   = 1'b1;
      do_push    = 1'b1;
    end else if (JUMP) begin
      raw_target = JUMP_TARGET;
      redirect   = 1'b1;
    end else if (BR_TAKEN) begin
      raw_target = br_sum;
      redirect   = 1'b1;
    end

    if (hold)          next_pc = cur_pc;
    else if (redirect) next_pc = align_target(raw_target);
    else               next_pc = seq_pc;
    next_misalign = redirect && is_misaligned(raw_target);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cur_pc    <= RESET_VEC;
      wr_ptr    <= '0;
      count     <= '0;
      misalign  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else begin
      cur_pc   <= next_pc;
      // A stall yields no redirect, so MISALIGN reads 0 while stalled.
      misalign <= next_misalign;
      if (uf_set) underflow <= 1'b1;
      if (do_push) begin
        ras[wr_ptr] <= seq_pc;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        if (count != DEPTH_V) count <= count + CNT_W'(1);
      end
      if (do_pop) begin
        wr_ptr <= wr_ptr - PTR_W'(1);
        count  <= count - CNT_W'(1);
      end
      if (do_replace) ras[top_idx] <= seq_pc;
    end
  end

  assign PC            = cur_pc;
  assign NPC           = next_pc;
  assign RAS_COUNT     = count;
  assign MISALIGN      = misalign;
  assign RAS_UNDERFLOW = underflow;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed testbench for pc_ctrl with default parameters
// (WIDTH=32, RESET_VEC=0, STEP=4, ALIGN_BITS=2, RAS_DEPTH=4).
module tb_pc_ctrl;

  logic        CLOCK;
  logic        RESET;
  logic        STALL;
  logic        TRAP;
  logic [31:0] TRAP_VEC;
  logic        BR_TAKEN;
  logic [31:0] BR_OFFSET;
  logic        JUMP;
  logic        CALL;
  logic        RET;
  logic [31:0] JUMP_TARGET;
  logic [31:0] PC;
  logic [31:0] NPC;
  logic [2:0]  RAS_COUNT;
  logic        MISALIGN;
  logic        RAS_UNDERFLOW;

  int checks = 0;
  int errors = 0;

  pc_ctrl dut (
    .CLOCK(CLOCK), .RESET(RESET), .STALL(STALL), .TRAP(TRAP),
    .TRAP_VEC(TRAP_VEC), .BR_TAKEN(BR_TAKEN), .BR_OFFSET(BR_OFFSET),
    .JUMP(JUMP), .CALL(CALL), .RET(RET), .JUMP_TARGET(JUMP_TARGET),
    .PC(PC), .NPC(NPC), .RAS_COUNT(RAS_COUNT), .MISALIGN(MISALIGN),
    .RAS_UNDERFLOW(RAS_UNDERFLOW)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle();
    STALL = 0; TRAP = 0; BR_TAKEN = 0; JUMP = 0; CALL = 0; RET = 0;
  endtask

  initial begin
    RESET = 1; idle();
    TRAP_VEC = 0; BR_OFFSET = 0; JUMP_TARGET = 0;
    #12;
    check("rst_pc", PC, 32'h0);
    check("rst_npc", NPC, 32'h4);
    check("rst_cnt", 32'(RAS_COUNT), 32'd0);
    check("rst_mis", 32'(MISALIGN), 32'd0);
    check("rst_uf", 32'(RAS_UNDERFLOW), 32'd0);
    RESET = 0;

    // Sequential fetch
    tick(); check("seq1", PC, 32'h4);
    tick(); check("seq2", PC, 32'h8);
    tick(); check("seq3", PC, 32'hC);

    // Asynchronous reset mid-cycle
    RESET = 1; #2;
    check("async_rst_pc", PC, 32'h0);
    RESET = 0;

    // Branch with wrap-around
    tick(); tick(); check("pre_br", PC, 32'h8);
    BR_TAKEN = 1; BR_OFFSET = 32'hFFFF_FFF0; #1;
    check("br_npc", NPC, 32'hFFFF_FFF8);
    tick(); check("br_pc", PC, 32'hFFFF_FFF8);
    BR_TAKEN = 0;
    tick(); check("wrap1", PC, 32'hFFFF_FFFC);
    tick(); check("wrap2", PC, 32'h0);

    // Stall holds PC
    STALL = 1; #1;
    check("stall_npc0", NPC, 32'h0);
    tick(); check("stall_pc1", PC, 32'h0);
    tick(); check("stall_pc2", PC, 32'h0);
    check("stall_npc2", NPC, 32'h0);
    check("stall_mis", 32'(MISALIGN), 32'd0);

    // Trap overrides stall
    TRAP = 1; TRAP_VEC = 32'h0000_2000;
    tick(); check("trap_pc", PC, 32'h2000);
    check("trap_cnt", 32'(RAS_COUNT), 32'd0);
    idle();

    // Five nested calls from 0x100..0x500 with depth 4
    for (int k = 1; k <= 5; k++) begin
      JUMP = 1; JUMP_TARGET = 32'(k) * 32'h100;
      tick(); JUMP = 0;
      CALL = 1; JUMP = 1; JUMP_TARGET = 32'h7000;
      tick(); CALL = 0; JUMP = 0;
      check("call_pc", PC, 32'h7000);
      check("call_cnt", 32'(RAS_COUNT), (k > 4) ? 32'd4 : 32'(k));
    end

    // Trap leaves a full RAS untouched
    TRAP = 1; TRAP_VEC = 32'h0000_3000;
    tick(); TRAP = 0;
    check("trap2_pc", PC, 32'h3000);
    check("trap2_cnt", 32'(RAS_COUNT), 32'd4);

    // Four returns, newest first
    RET = 1;
    tick(); check("ret1_pc", PC, 32'h504); check("ret1_cnt", 32'(RAS_COUNT), 32'd3);
    tick(); check("ret2_pc", PC, 32'h404); check("ret2_cnt", 32'(RAS_COUNT), 32'd2);
    tick(); check("ret3_pc", PC, 32'h304); check("ret3_cnt", 32'(RAS_COUNT), 32'd1);
    tick(); check("ret4_pc", PC, 32'h204); check("ret4_cnt", 32'(RAS_COUNT), 32'd0);
    check("ret4_uf", 32'(RAS_UNDERFLOW), 32'd0);
    // Underflow
    tick(); check("ret5_pc", PC, 32'h208);
    check("ret5_uf", 32'(RAS_UNDERFLOW), 32'd1);
    RET = 0;
    tick(); check("uf_pc", PC, 32'h20C);
    check("uf_sticky", 32'(RAS_UNDERFLOW), 32'd1);

    // Misaligned jump
    JUMP = 1; JUMP_TARGET = 32'h0001_0002;
    tick(); JUMP = 0;
    check("mis_pc", PC, 32'h0001_0000);
    check("mis_set", 32'(MISALIGN), 32'd1);
    tick();
    check("mis_clr", 32'(MISALIGN), 32'd0);
    check("mis_seq", PC, 32'h0001_0004);

    // CALL+RET swap: top 0x204, PC 0x800
    JUMP = 1; JUMP_TARGET = 32'h200;
    tick(); JUMP = 0;
    CALL = 1; JUMP_TARGET = 32'h7000;
    tick(); CALL = 0;
    check("swap_setup_cnt", 32'(RAS_COUNT), 32'd1);
    JUMP = 1; JUMP_TARGET = 32'h800;
    tick(); JUMP = 0;
    check("swap_setup_pc", PC, 32'h800);
    CALL = 1; RET = 1; JUMP_TARGET = 32'h6000;
    tick(); CALL = 0; RET = 0;
    check("swap_pc", PC, 32'h204);
    check("swap_cnt", 32'(RAS_COUNT), 32'd1);
    RET = 1;
    tick(); RET = 0;
    check("swap_top", PC, 32'h804);
    check("swap_cnt0", 32'(RAS_COUNT), 32'd0);

    // Reset clears sticky underflow
    RESET = 1; #2; RESET = 0;
    check("rst2_uf", 32'(RAS_UNDERFLOW), 32'd0);

    // CALL+RET on empty RAS behaves as CALL and flags underflow
    CALL = 1; RET = 1; JUMP_TARGET = 32'h5000;
    tick(); CALL = 0; RET = 0;
    check("cr_empty_pc", PC, 32'h5000);
    check("cr_empty_cnt", 32'(RAS_COUNT), 32'd1);
    check("cr_empty_uf", 32'(RAS_UNDERFLOW), 32'd1);

    // Reset in the middle of a call sequence
    RESET = 1; #2;
    check("rst3_pc", PC, 32'h0);
    check("rst3_cnt", 32'(RAS_COUNT), 32'd0);
    check("rst3_uf", 32'(RAS_UNDERFLOW), 32'd0);
    RESET = 0;
    tick(); check("rst3_seq", PC, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Parametrised program-counter controller: the next-generation PC register for the CPU fetch stage. Holds the current fetch address and selects the next one from sequential increment, PC-relative branch, absolute jump, call/return through an internal return-address stack (RAS), or trap vector. It also supports stall, target alignment checking and RAS occupancy reporting. It sits between the decode/execute redirect logic and the instruction memory address port.

## Interface
- WIDTH, 32, address width in bits
- RESET_VEC, 0, PC value loaded on reset
- STEP, 4, sequential increment in bytes
- ALIGN_BITS, 2, low target bits that must be zero (0 disables the check)
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

- CLOCK  input  1  system clock, rising-edge active
- RESET  input  1  asynchronous, active-high reset
- STALL  input  1  hold PC (overridden by TRAP)
- TRAP  input  1  redirect to TRAP_VEC
- TRAP_VEC  input  WIDTH  trap target
- BR_TAKEN  input  1  take PC-relative branch
- BR_OFFSET  input  WIDTH  two's-complement byte offset
- JUMP  input  1  absolute jump to JUMP_TARGET
- CALL  input  1  push PC+STEP, go to JUMP_TARGET
- RET  input  1  pop RAS, go to popped address
- JUMP_TARGET  input  WIDTH  target for JUMP/CALL
- PC  output  WIDTH  current fetch address (registered)
- NPC  output  WIDTH  next PC (combinational from current inputs)
- RAS_COUNT  output  $clog2(RAS_DEPTH)+1  valid RAS entries
- MISALIGN  output  1  registered one-cycle pulse: last accepted redirect target was misaligned
- RAS_UNDERFLOW  output  1  sticky: RET issued with empty RAS

## Operation
- Next-PC priority, highest first: TRAP; STALL (hold); RET (including RET+CALL); CALL; JUMP; BR_TAKEN; sequential PC+STEP.
- TRAP ignores STALL and leaves the RAS untouched.
- STALL without TRAP: PC, RAS, RAS_COUNT and all flags hold. MISALIGN reads 0.
- Arithmetic: PC+STEP and PC+BR_OFFSET are computed modulo 2^WIDTH; the carry is discarded and wrap is legal.
- Alignment: every redirect target (TRAP_VEC, JUMP_TARGET, branch sum, popped address) has its low ALIGN_BITS forced to 0 before loading. If any of those bits was set, MISALIGN = 1 on the next cycle.
- CALL: push PC+STEP, load JUMP_TARGET.
  - When RAS is full, the push overwrites the oldest entry (circular) and RAS_COUNT stays at RAS_DEPTH.
- RET with RAS_COUNT>0: load the top entry, decrement the count.
- RET with RAS_COUNT=0: PC <= PC+STEP, set RAS_UNDERFLOW (sticky), RAS unchanged.
- RET and CALL in the same cycle:
  - Load the top entry, and replace the top entry with PC+STEP; RAS_COUNT unchanged.
  - If RAS is empty: behave as CALL and set RAS_UNDERFLOW.
- JUMP and CALL together: CALL wins (push performed).
- NPC always equals the value PC will take at the next edge, given current inputs. With STALL=1 and no TRAP, NPC = PC.

## Timing
- PC, RAS pointer/entries, RAS_COUNT, MISALIGN and RAS_UNDERFLOW update on the rising CLOCK edge.
- Redirect latency: a request sampled at edge N appears on PC immediately after edge N. No bubble is inserted by this block.
- RESET asserted (asynchronous, at any time, including mid-call sequence):
  - PC = RESET_VEC immediately.
  - RAS_COUNT = 0, RAS entries = 0, RAS pointer = 0.
  - MISALIGN = 0, RAS_UNDERFLOW = 0.
  - NPC = RESET_VEC + STEP computed from the held PC.
- First sequential update occurs at the first rising edge after RESET deasserts.
- RAS_UNDERFLOW clears only on RESET.

## Test plan
- Reset/sequential: RESET pulse, then 3 edges, no requests -> PC = 0x0, 0x4, 0x8, 0xC. Assert RESET mid-cycle -> PC = 0x0 without waiting for an edge.
- Branch wrap and stall: PC=0x8, BR_TAKEN, BR_OFFSET=0xFFFF_FFF0 -> PC=0xFFFF_FFF8; next sequential -> 0xFFFF_FFFC then 0x0000_0000. STALL for 2 edges -> PC held, NPC=PC.
- Trap over stall: STALL=1, TRAP=1, TRAP_VEC=0x0000_2000 -> PC=0x2000 next edge, RAS_COUNT unchanged.
- Nested calls past depth (RAS_DEPTH=4): 5 CALLs from PCs 0x100, 0x200, 0x300, 0x400, 0x500 -> RAS_COUNT saturates at 4; 4 RETs return 0x504, 0x404, 0x304, 0x204. A 5th RET -> PC+4, RAS_UNDERFLOW=1 and stays 1.
- Misaligned jump: JUMP, JUMP_TARGET=0x0001_0002 -> PC=0x0001_0000, MISALIGN=1 for exactly one cycle.
- Simultaneous CALL+RET with RAS top=0x204, PC=0x800 -> PC=0x204, top becomes 0x804, RAS_COUNT unchanged.
